// File: rtl/se_sched_pkg.sv
// Shared types and default sizing for the self-composition scheduler.
package se_sched_pkg;

    localparam int DEF_DW         = 128;
    localparam int DEF_IW         = 8;
    localparam int DEF_CW         = 8;
    localparam int DEF_MAX_CYCLES = 200;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REPORT
    } state_t;

    typedef struct packed {
        logic [DEF_DW-1:0] resultA;
        logic [DEF_DW-1:0] resultB;
        logic [DEF_CW-1:0] stampA;
        logic [DEF_CW-1:0] stampB;
        logic              leak;
        logic              timeout;
    } report_t;

endpackage

// File: rtl/se_lane_tracker.sv
// Per-lane issue/complete bookkeeping: accept and done flags, result capture
// and completion stamp.
module se_lane_tracker
    import se_sched_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int CW         = DEF_CW,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          issue,
    input  logic          active,
    input  logic          expire,
    input  logic [CW-1:0] counter,
    input  logic          in_ready,
    input  logic          out_valid,
    input  logic [DW-1:0] out_result,
    output logic          in_valid,
    output logic          out_ready,
    output logic          acc_next,
    output logic          done_next,
    output logic [DW-1:0] result,
    output logic [CW-1:0] stamp
);

    logic acc;
    logic done;
    logic out_fire;

    // Results are only taken once the lane has accepted the request.
    assign in_valid  = issue & ~acc;
    assign out_ready = active & acc & ~done;
    assign out_fire  = out_valid & out_ready;
    assign acc_next  = acc | (in_valid & in_ready);
    assign done_next = done | out_fire;

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            stamp  <= '0;
        end else if (start) begin
            acc    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            stamp  <= '0;
        end else begin
            acc  <= acc_next;
            done <= done_next;
            if (out_fire) begin
                result <= out_result;
                stamp  <= counter;
            end else if (expire && !done) begin
                stamp <= CW'(MAX_CYCLES);
            end
        end
    end

endmodule

// File: rtl/se_selfcomp_scheduler.sv
// Issues one request to two SE copies in lockstep, stamps each lane's
// completion and reports timing differences as a leak.
module se_selfcomp_scheduler
    import se_sched_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int IW         = DEF_IW,
    parameter int CW         = DEF_CW,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [IW-1:0] req_inst,
    input  logic [DW-1:0] req_op1,
    input  logic [DW-1:0] req_op2,
    input  logic [DW-1:0] req_condA,
    input  logic [DW-1:0] req_condB,
    output logic [IW-1:0] se_inst,
    output logic [DW-1:0] se_op1,
    output logic [DW-1:0] se_op2,
    output logic [DW-1:0] se_condA,
    output logic [DW-1:0] se_condB,
    output logic          a_in_valid,
    output logic          b_in_valid,
    input  logic          a_in_ready,
    input  logic          b_in_ready,
    input  logic [DW-1:0] a_out_result,
    input  logic [DW-1:0] b_out_result,
    input  logic          a_out_valid,
    input  logic          b_out_valid,
    output logic          a_out_ready,
    output logic          b_out_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_resultA,
    output logic [DW-1:0] rsp_resultB,
    output logic [CW-1:0] rsp_stampA,
    output logic [CW-1:0] rsp_stampB,
    output logic          rsp_leak,
    output logic          rsp_timeout,
    output logic          timingLeak,
    output logic          timingLeakDone,
    output logic          bothValid,
    output logic          init
);

    state_t        state;
    logic [CW-1:0] counter;
    logic          start, issue, active, expire;
    logic          a_acc_next, b_acc_next, a_done_next, b_done_next;

    assign issue     = (state == ISSUE);
    assign active    = issue | (state == WAIT);
    assign start     = (state == IDLE) & req_valid;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == REPORT);
    assign bothValid = a_out_valid & b_out_valid;

    // A lane finishing on the last allowed cycle still counts as on time.
    assign expire   = active & (counter == CW'(MAX_CYCLES - 1)) & ~(a_done_next & b_done_next);
    assign rsp_leak = rsp_valid & ((rsp_stampA != rsp_stampB) | rsp_timeout);

    se_lane_tracker #(.DW(DW), .CW(CW), .MAX_CYCLES(MAX_CYCLES)) u_lane_a (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .issue      (issue),
        .active     (active),
        .expire     (expire),
        .counter    (counter),
        .in_ready   (a_in_ready),
        .out_valid  (a_out_valid),
        .out_result (a_out_result),
        .in_valid   (a_in_valid),
        .out_ready  (a_out_ready),
        .acc_next   (a_acc_next),
        .done_next  (a_done_next),
        .result     (rsp_resultA),
        .stamp      (rsp_stampA)
    );

    se_lane_tracker #(.DW(DW), .CW(CW), .MAX_CYCLES(MAX_CYCLES)) u_lane_b (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .issue      (issue),
        .active     (active),
        .expire     (expire),
        .counter    (counter),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_result (b_out_result),
        .in_valid   (b_in_valid),
        .out_ready  (b_out_ready),
        .acc_next   (b_acc_next),
        .done_next  (b_done_next),
        .result     (rsp_resultB),
        .stamp      (rsp_stampB)
    );

    always_ff @(posedge clock) begin
        init <= ~reset;
        if (!reset) begin
            state          <= IDLE;
            counter        <= '0;
            se_inst        <= '0;
            se_op1         <= '0;
            se_op2         <= '0;
            se_condA       <= '0;
            se_condB       <= '0;
            rsp_timeout    <= 1'b0;
            timingLeak     <= 1'b0;
            timingLeakDone <= 1'b0;
        end else begin
            timingLeakDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        se_inst     <= req_inst;
                        se_op1      <= req_op1;
                        se_op2      <= req_op2;
                        se_condA    <= req_condA;
                        se_condB    <= req_condB;
                        counter     <= '0;
                        rsp_timeout <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (counter != CW'(MAX_CYCLES))
                        counter <= counter + 1'b1;
                    if (expire) begin
                        rsp_timeout <= 1'b1;
                        state       <= REPORT;
                    end else if (issue && a_acc_next && b_acc_next) begin
                        state <= WAIT;
                    end else if (!issue && a_done_next && b_done_next) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    if (rsp_ready) begin
                        timingLeakDone <= 1'b1;
                        timingLeak     <= timingLeak | rsp_leak;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_se_selfcomp_scheduler.sv
// Directed and randomized transactions against a cycle-count model of the
// scheduler's stamps, leak and handshakes.
module tb_se_selfcomp_scheduler;
    import se_sched_pkg::*;

    localparam int DW   = 128;
    localparam int IW   = 8;
    localparam int CW   = 8;
    localparam int MAXC = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [IW-1:0] req_inst;
    logic [DW-1:0] req_op1, req_op2, req_condA, req_condB;
    logic [IW-1:0] se_inst;
    logic [DW-1:0] se_op1, se_op2, se_condA, se_condB;
    logic          a_in_valid, b_in_valid, a_in_ready, b_in_ready;
    logic [DW-1:0] a_out_result, b_out_result;
    logic          a_out_valid, b_out_valid, a_out_ready, b_out_ready;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_resultA, rsp_resultB;
    logic [CW-1:0] rsp_stampA, rsp_stampB;
    logic          rsp_leak, rsp_timeout, timingLeak, timingLeakDone, bothValid, init;

    int errors = 0;
    int checks = 0;
    bit model_leak = 1'b0;

    se_selfcomp_scheduler #(.DW(DW), .IW(IW), .CW(CW), .MAX_CYCLES(MAXC)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
        .req_op1(req_op1), .req_op2(req_op2), .req_condA(req_condA), .req_condB(req_condB),
        .se_inst(se_inst), .se_op1(se_op1), .se_op2(se_op2), .se_condA(se_condA), .se_condB(se_condB),
        .a_in_valid(a_in_valid), .b_in_valid(b_in_valid), .a_in_ready(a_in_ready), .b_in_ready(b_in_ready),
        .a_out_result(a_out_result), .b_out_result(b_out_result),
        .a_out_valid(a_out_valid), .b_out_valid(b_out_valid),
        .a_out_ready(a_out_ready), .b_out_ready(b_out_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_resultA(rsp_resultA), .rsp_resultB(rsp_resultB),
        .rsp_stampA(rsp_stampA), .rsp_stampB(rsp_stampB),
        .rsp_leak(rsp_leak), .rsp_timeout(rsp_timeout),
        .timingLeak(timingLeak), .timingLeakDone(timingLeakDone),
        .bothValid(bothValid), .init(init)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // A lane accepts at counter d and presents its result l cycles after its
    // first out_ready cycle, so it completes at counter d+1+l.
    task automatic txn(input int da, input int la, input int db, input int lb, input int bp,
                       input bit a_never, input bit b_never);
        logic [DW-1:0] ra, rb, op1, op2, ca, cb;
        logic [IW-1:0] inst;
        report_t       e;
        int            sa, sb, last;
        ra = rnd(); rb = rnd(); op1 = rnd(); op2 = rnd(); ca = rnd(); cb = rnd();
        inst = IW'($urandom());
        sa = a_never ? MAXC : da + 1 + la;
        sb = b_never ? MAXC : db + 1 + lb;
        e.timeout = a_never | b_never;
        e.resultA = a_never ? '0 : ra;
        e.resultB = b_never ? '0 : rb;
        e.stampA  = CW'(sa);
        e.stampB  = CW'(sb);
        e.leak    = (sa != sb) || e.timeout;
        last = e.timeout ? MAXC - 1 : ((sa > sb) ? sa : sb);

        chk("idle_req_ready", DW'(req_ready), DW'(1));
        req_valid = 1'b1; req_inst = inst; req_op1 = op1; req_op2 = op2;
        req_condA = ca; req_condB = cb;
        step();
        req_valid = 1'b0; req_inst = ~inst; req_op1 = rnd(); req_op2 = rnd();
        req_condA = rnd(); req_condB = rnd();
        chk("se_op1", se_op1, op1);
        chk("se_op2", se_op2, op2);
        chk("se_condA", se_condA, ca);
        chk("se_condB", se_condB, cb);

        for (int c = 0; c <= last; c++) begin
            chk("a_in_valid", DW'(a_in_valid), DW'(c <= da));
            chk("b_in_valid", DW'(b_in_valid), DW'(c <= db));
            chk("a_out_ready", DW'(a_out_ready), DW'(c > da && c <= sa));
            chk("b_out_ready", DW'(b_out_ready), DW'(c > db && c <= sb));
            chk("busy_req_ready", DW'(req_ready), DW'(0));
            chk("busy_rsp_valid", DW'(rsp_valid), DW'(0));
            chk("busy_se_inst", DW'(se_inst), DW'(inst));
            chk("busy_leak_done", DW'(timingLeakDone), DW'(0));
            a_in_ready   = (c >= da);
            b_in_ready   = (c >= db);
            a_out_valid  = (!a_never && c >= sa) || (c <= da && $urandom_range(0, 1) == 1);
            b_out_valid  = (!b_never && c >= sb) || (c <= db && $urandom_range(0, 1) == 1);
            a_out_result = (!a_never && c >= sa) ? ra : rnd();
            b_out_result = (!b_never && c >= sb) ? rb : rnd();
            #1;
            chk("both_valid", DW'(bothValid), DW'(a_out_valid & b_out_valid));
            step();
        end

        a_in_ready = 1'b0; b_in_ready = 1'b0; a_out_valid = 1'b0; b_out_valid = 1'b0;
        for (int k = 0; k <= bp; k++) begin
            chk("rsp_valid", DW'(rsp_valid), DW'(1));
            chk("rpt_req_ready", DW'(req_ready), DW'(0));
            chk("rsp_resultA", rsp_resultA, e.resultA);
            chk("rsp_resultB", rsp_resultB, e.resultB);
            chk("rsp_stampA", DW'(rsp_stampA), DW'(e.stampA));
            chk("rsp_stampB", DW'(rsp_stampB), DW'(e.stampB));
            chk("rsp_leak", DW'(rsp_leak), DW'(e.leak));
            chk("rsp_timeout", DW'(rsp_timeout), DW'(e.timeout));
            chk("rpt_se_inst", DW'(se_inst), DW'(inst));
            chk("rpt_timing_leak", DW'(timingLeak), DW'(model_leak));
            req_valid = (k < bp);
            rsp_ready = (k == bp);
            step();
        end
        req_valid = 1'b0; rsp_ready = 1'b0;
        model_leak = model_leak | e.leak;
        chk("leak_done_pulse", DW'(timingLeakDone), DW'(1));
        chk("timing_leak", DW'(timingLeak), DW'(model_leak));
        chk("post_req_ready", DW'(req_ready), DW'(1));
        chk("post_rsp_valid", DW'(rsp_valid), DW'(0));
        step();
        chk("leak_done_end", DW'(timingLeakDone), DW'(0));
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_inst = '0; req_op1 = '0; req_op2 = '0;
        req_condA = '0; req_condB = '0; a_in_ready = 1'b0; b_in_ready = 1'b0;
        a_out_result = '0; b_out_result = '0; a_out_valid = 1'b0; b_out_valid = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", DW'(req_ready), DW'(1));
        chk("rst_init", DW'(init), DW'(1));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_timing_leak", DW'(timingLeak), DW'(0));
        chk("rst_se_op1", se_op1, '0);
        chk("rst_stampA", DW'(rsp_stampA), DW'(0));
        reset = 1'b1;
        step();
        chk("init_low", DW'(init), DW'(0));

        txn(0, 2, 0, 2, 0, 1'b0, 1'b0);   // equal lanes
        txn(0, 4, 0, 2, 1, 1'b0, 1'b0);   // latency skew 5/3
        txn(0, 2, 0, 2, 0, 1'b0, 1'b0);   // sticky leak remains
        txn(0, 2, 2, 2, 0, 1'b0, 1'b0);   // accept skew
        txn(0, 2, 0, 0, 0, 1'b0, 1'b1);   // B never completes
        txn(1, 1, 0, 3, 5, 1'b0, 1'b0);   // report backpressure

        // Reset in WAIT while the sticky flag is set.
        req_valid = 1'b1; req_inst = 8'h5a; req_op1 = rnd();
        step();
        req_valid = 1'b0; a_in_ready = 1'b1; b_in_ready = 1'b1;
        step();
        a_in_ready = 1'b0; b_in_ready = 1'b0;
        chk("wait_a_out_ready", DW'(a_out_ready), DW'(1));
        reset = 1'b0;
        step();
        chk("mid_rst_req_ready", DW'(req_ready), DW'(1));
        chk("mid_rst_a_in_valid", DW'(a_in_valid), DW'(0));
        chk("mid_rst_a_out_ready", DW'(a_out_ready), DW'(0));
        chk("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("mid_rst_timing_leak", DW'(timingLeak), DW'(0));
        chk("mid_rst_init", DW'(init), DW'(1));
        chk("mid_rst_se_inst", DW'(se_inst), DW'(0));
        chk("mid_rst_rsp_leak", DW'(rsp_leak), DW'(0));
        reset = 1'b1;
        model_leak = 1'b0;
        step();
        chk("mid_rst_init_low", DW'(init), DW'(0));
        chk("mid_rst_no_rsp", DW'(rsp_valid), DW'(0));

        txn(0, 1, 0, 1, 0, 1'b0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            txn($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
